// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
// Data memory is 32-bit words held as two 16-bit half-words in external SRAM.
package mem_stage_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DATA_BASE_DEF   = 1024;
  localparam int SRAM_DW         = 16;
  localparam int SRAM_AW_DEF     = 18;
  localparam int WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: splits 32-bit loads/stores into two timed 16-bit SRAM
// phases (low half first) and stalls the pipeline via ready until the access is done.
//
// state | meaning
// IDLE  | waiting for a request; ready follows ~req combinationally
// LO    | low half-word phase on the SRAM bus, held WAIT_CYCLES cycles
// HI    | high half-word phase on the SRAM bus, held WAIT_CYCLES cycles
// DONE  | single ready cycle; pipeline advances, then back to IDLE
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int DATA_BASE   = DATA_BASE_DEF,
  parameter int SRAM_AW     = SRAM_AW_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_en,
  input  logic               MEM_W_en,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        Val_Rm,
  output logic               ready,
  output logic [31:0]        Mem_read_value,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [SRAM_DW-1:0] SRAM_DQ_out,
  output logic               SRAM_DQ_oe,
  input  logic [SRAM_DW-1:0] SRAM_DQ_in,
  output logic               SRAM_WE_N
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic               op_store;
  logic [SRAM_AW-1:0] addr_lo;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic [31:0]        rd_hold;

  logic               req;
  logic               last;
  logic [31:0]        offset;
  logic [SRAM_AW-1:0] addr_lo_nxt;
  logic [SRAM_AW-1:0] addr_hi;

  assign req    = MEM_R_en | MEM_W_en;
  assign last   = (cnt == CNT_LAST);
  assign offset = ALU_result - 32'(DATA_BASE);
  // Word index shifted back up to half-word granularity; wraps modulo 2^SRAM_AW.
  assign addr_lo_nxt = SRAM_AW'({offset >> 2, 1'b0});
  assign addr_hi     = addr_lo + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LO;
          cnt_nxt   = '0;
        end
      end
      LO: begin
        if (last) begin
          state_nxt = HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HI: begin
        if (last) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A simultaneous read+write request is taken as a store.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_store <= 1'b0;
      addr_lo  <= '0;
      wdata    <= '0;
      rdata    <= '0;
      rd_hold  <= '0;
    end else begin
      if (state == IDLE && req) begin
        op_store <= MEM_W_en;
        addr_lo  <= addr_lo_nxt;
        wdata    <= Val_Rm;
      end
      if (state == LO && last && !op_store) rdata[15:0]  <= SRAM_DQ_in;
      if (state == HI && last && !op_store) rdata[31:16] <= SRAM_DQ_in;
      if (state == DONE && !op_store)       rd_hold      <= rdata;
    end
  end

  // The assembled word is visible already in DONE; rd_hold keeps it afterwards.
  assign Mem_read_value = (state == DONE && !op_store) ? rdata : rd_hold;

  always_comb begin
    ready       = 1'b0;
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    unique case (state)
      IDLE: ready = ~req;
      LO: begin
        SRAM_ADDR   = addr_lo;
        SRAM_DQ_out = wdata[15:0];
        SRAM_DQ_oe  = op_store;
        SRAM_WE_N   = ~op_store;
      end
      HI: begin
        SRAM_ADDR   = addr_hi;
        SRAM_DQ_out = wdata[31:16];
        SRAM_DQ_oe  = op_store;
        SRAM_WE_N   = ~op_store;
      end
      DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: per-cycle expected bus/handshake values are queued
// when a request is driven and checked against the DUT on the falling edge.
module tb_mem_stage_sram_ctrl;

  localparam int W = 2;

  typedef struct {
    logic        rdy;
    logic [17:0] addr;
    logic [15:0] dq;
    logic        we_n;
    logic        oe;
    logic [31:0] mrv;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        MEM_R_en, MEM_W_en;
  logic [31:0] ALU_result, Val_Rm;
  logic        ready;
  logic [31:0] Mem_read_value;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
  logic        SRAM_DQ_oe, SRAM_WE_N;

  logic        r1_en, w1_en;
  logic [31:0] a1, d1;
  logic        ready1;
  logic [31:0] mrv1;
  logic [17:0] addr1;
  logic [15:0] dq_out1, dq_in1;
  logic        oe1, we_n1;

  logic [15:0] sram    [0:255];
  logic [15:0] ref_mem [0:255];
  logic        sram_init;
  logic [17:0] last_a;
  int          run;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] exp_mrv;
  int          n_checks;
  int          n_fails;

  mem_stage_sram_ctrl #(.DATA_BASE(1024), .SRAM_AW(18), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .MEM_R_en(MEM_R_en), .MEM_W_en(MEM_W_en),
    .ALU_result(ALU_result), .Val_Rm(Val_Rm), .ready(ready),
    .Mem_read_value(Mem_read_value), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
    .SRAM_DQ_in(SRAM_DQ_in), .SRAM_WE_N(SRAM_WE_N)
  );

  mem_stage_sram_ctrl #(.DATA_BASE(1024), .SRAM_AW(18), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .MEM_R_en(r1_en), .MEM_W_en(w1_en),
    .ALU_result(a1), .Val_Rm(d1), .ready(ready1),
    .Mem_read_value(mrv1), .SRAM_ADDR(addr1),
    .SRAM_DQ_out(dq_out1), .SRAM_DQ_oe(oe1),
    .SRAM_DQ_in(dq_in1), .SRAM_WE_N(we_n1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: a write lands only after WE_N has been low for a full phase at one address.
  assign SRAM_DQ_in = sram[SRAM_ADDR[7:0]];
  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= 16'h1000 + 16'(i);
      run <= 0;
    end else if (!SRAM_WE_N) begin
      last_a <= SRAM_ADDR;
      if (run != 0 && SRAM_ADDR == last_a) begin
        run <= run + 1;
        if (run + 1 == W) sram[SRAM_ADDR[7:0]] <= SRAM_DQ_out;
      end else begin
        run <= 1;
      end
    end else begin
      run <= 0;
    end
  end

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d);
    exp_t        x;
    logic [31:0] off;
    logic [17:0] lo;
    logic [7:0]  il, ih;
    logic [31:0] nv;
    off = a - 32'd1024;
    lo  = 18'((off / 4) * 2);
    il  = lo[7:0];
    ih  = il + 8'd1;
    nv  = {ref_mem[ih], ref_mem[il]};
    MEM_R_en = rd; MEM_W_en = wr; ALU_result = a; Val_Rm = d;
    for (int c = 0; c <= 2 * W + 1; c++) begin
      x.rdy = 1'b0; x.addr = '0; x.dq = '0; x.we_n = 1'b1; x.oe = 1'b0; x.mrv = exp_mrv;
      if (c >= 1 && c <= W) begin
        x.addr = lo; x.dq = d[15:0]; x.we_n = ~wr; x.oe = wr;
      end else if (c > W && c <= 2 * W) begin
        x.addr = lo + 18'd1; x.dq = d[31:16]; x.we_n = ~wr; x.oe = wr;
      end else if (c == 2 * W + 1) begin
        x.rdy = 1'b1;
        if (!wr) x.mrv = nv;
      end
      q.push_back(x);
    end
    if (wr) begin
      ref_mem[il] = d[15:0];
      ref_mem[ih] = d[31:16];
    end else begin
      exp_mrv = nv;
    end
    repeat (2 * W + 2) @(posedge clk);
    #1;
  endtask

  task automatic end_req();
    MEM_R_en = 1'b0; MEM_W_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sram_init = 1'b1; end_req(); ALU_result = '0; Val_Rm = '0;
    r1_en = 1'b0; w1_en = 1'b0; a1 = '0; d1 = '0; dq_in1 = '0;
    exp_mrv = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h1000 + 16'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fails++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_checks++; if (Mem_read_value !== 32'h0) begin n_fails++; $display("FAIL reset_mrv: got %h expected 0", Mem_read_value); end
    n_checks++; if (SRAM_WE_N !== 1'b1 || SRAM_DQ_oe !== 1'b0) begin n_fails++; $display("FAIL reset_bus: got we_n=%b oe=%b expected we_n=1 oe=0", SRAM_WE_N, SRAM_DQ_oe); end
    n_checks++; if (SRAM_ADDR !== 18'h0) begin n_fails++; $display("FAIL reset_addr: got %h expected 0", SRAM_ADDR); end
    MEM_R_en = 1'b1;
    #1;
    n_checks++; if (ready !== 1'b0) begin n_fails++; $display("FAIL reset_ready_comb: got %b expected 0", ready); end
    end_req();
    @(posedge clk);
    #1;
    rst = 1'b0; sram_init = 1'b0;
  endtask

  task automatic test_store();
    do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    end_req();
    n_checks++; if (sram[2] !== 16'hBEEF) begin n_fails++; $display("FAIL store_lo: got %h expected beef", sram[2]); end
    n_checks++; if (sram[3] !== 16'hDEAD) begin n_fails++; $display("FAIL store_hi: got %h expected dead", sram[3]); end
  endtask

  task automatic test_load();
    do_access(1'b1, 1'b0, 32'd1028, 32'h0BADF00D);
    end_req();
    @(negedge clk);
    n_checks++; if (Mem_read_value !== 32'hDEADBEEF) begin n_fails++; $display("FAIL load_hold: got %h expected deadbeef", Mem_read_value); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle();
    exp_t x;
    end_req();
    for (int c = 0; c < 10; c++) begin
      x.rdy = 1'b1; x.addr = '0; x.dq = '0; x.we_n = 1'b1; x.oe = 1'b0; x.mrv = exp_mrv;
      q.push_back(x);
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 1'b0, 32'd1032, 32'h55AA55AA);
    do_access(1'b0, 1'b1, 32'd1036, 32'hCAFEF00D);
    end_req();
    n_checks++; if (Mem_read_value !== 32'h10051004) begin n_fails++; $display("FAIL b2b_load: got %h expected 10051004", Mem_read_value); end
    n_checks++; if (sram[6] !== 16'hF00D || sram[7] !== 16'hCAFE) begin n_fails++; $display("FAIL b2b_store: got %h_%h expected cafe_f00d", sram[7], sram[6]); end
  endtask

  task automatic test_both_en();
    do_access(1'b1, 1'b1, 32'd1024, 32'h00010002);
    end_req();
    n_checks++; if (sram[0] !== 16'h0002 || sram[1] !== 16'h0001) begin n_fails++; $display("FAIL both_store: got %h_%h expected 0001_0002", sram[1], sram[0]); end
    n_checks++; if (Mem_read_value !== 32'h10051004) begin n_fails++; $display("FAIL both_mrv: got %h expected 10051004", Mem_read_value); end
  endtask

  task automatic test_reset_mid_store();
    MEM_W_en = 1'b1; ALU_result = 32'd1028; Val_Rm = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; end_req();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_mem[2] = 16'h5678;
    exp_mrv = '0;
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fails++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
    n_checks++; if (SRAM_WE_N !== 1'b1 || SRAM_DQ_oe !== 1'b0) begin n_fails++; $display("FAIL rstmid_bus: got we_n=%b oe=%b expected we_n=1 oe=0", SRAM_WE_N, SRAM_DQ_oe); end
    n_checks++; if (Mem_read_value !== 32'h0) begin n_fails++; $display("FAIL rstmid_mrv: got %h expected 0", Mem_read_value); end
    n_checks++; if (sram[3] !== 16'hDEAD) begin n_fails++; $display("FAIL rstmid_hi_kept: got %h expected dead", sram[3]); end
    n_checks++; if (sram[2] !== 16'h5678) begin n_fails++; $display("FAIL rstmid_lo_done: got %h expected 5678", sram[2]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wait1();
    int lows;
    int we_lows;
    bit seen;
    lows = 0; we_lows = 0; seen = 1'b0;
    w1_en = 1'b1; a1 = 32'd1040; d1 = 32'h0A0B0C0D;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ready1 === 1'b1) seen = 1'b1;
      else lows++;
      if (we_n1 === 1'b0) we_lows++;
    end
    @(posedge clk);
    #1;
    w1_en = 1'b0;
    n_checks++; if (!seen) begin n_fails++; $display("FAIL w1_timeout: got no ready within 20 cycles expected ready"); end
    n_checks++; if (lows != 3) begin n_fails++; $display("FAIL w1_stall: got %0d expected 3", lows); end
    n_checks++; if (we_lows != 2) begin n_fails++; $display("FAIL w1_we_cycles: got %0d expected 2", we_lows); end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    fork
      forever begin
        @(negedge clk);
        if (q.size() > 0) begin
          e = q.pop_front();
          n_checks++; if (ready !== e.rdy) begin n_fails++; $display("FAIL sb_ready: got %b expected %b", ready, e.rdy); end
          n_checks++; if (SRAM_ADDR !== e.addr) begin n_fails++; $display("FAIL sb_addr: got %h expected %h", SRAM_ADDR, e.addr); end
          n_checks++; if (SRAM_DQ_out !== e.dq) begin n_fails++; $display("FAIL sb_dq_out: got %h expected %h", SRAM_DQ_out, e.dq); end
          n_checks++; if (SRAM_WE_N !== e.we_n) begin n_fails++; $display("FAIL sb_we_n: got %b expected %b", SRAM_WE_N, e.we_n); end
          n_checks++; if (SRAM_DQ_oe !== e.oe) begin n_fails++; $display("FAIL sb_oe: got %b expected %b", SRAM_DQ_oe, e.oe); end
          n_checks++; if (Mem_read_value !== e.mrv) begin n_fails++; $display("FAIL sb_mrv: got %h expected %h", Mem_read_value, e.mrv); end
        end
      end
    join_none

    test_reset();
    test_store();
    test_load();
    test_idle();
    test_back_to_back();
    test_both_en();
    test_idle();
    test_reset_mid_store();
    test_idle();
    test_wait1();

    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (sram[i] !== ref_mem[i]) begin
        n_fails++;
        $display("FAIL final_mem[%0d]: got %h expected %h", i, sram[i], ref_mem[i]);
      end
    end
    n_checks++; if (q.size() != 0) begin n_fails++; $display("FAIL sb_drain: got %0d pending expected 0", q.size()); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
